uart_frame_parser: RTL
======================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the stream byte width.
REQ-002 The block SHALL have parameter SYNC, default 8'hA5, meaning the frame start byte.
REQ-003 The block SHALL have parameter MAXLEN, default 16, meaning the maximum payload byte count (range 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-006 The block SHALL have port sti_tvalid, input, 1 bit: the input byte stream valid, fed from the uart_rx stream output.
REQ-007 The block SHALL have port sti_tdata, input, DW bits: the input byte.
REQ-008 The block SHALL have port sti_tready, output, 1 bit: the input ready.
REQ-009 The block SHALL have port sto_tvalid, output, 1 bit: the payload stream valid.
REQ-010 The block SHALL have port sto_tdata, output, DW bits: the payload byte.
REQ-011 The block SHALL have port sto_tlast, output, 1 bit: marks the last payload byte of a frame.
REQ-012 The block SHALL have port sto_tready, input, 1 bit: the payload ready.
REQ-013 The block SHALL have port err_len, output, 1 bit: a one-cycle pulse flagging an illegal length byte.
REQ-014 The block SHALL have port err_chk, output, 1 bit: a one-cycle pulse flagging a checksum mismatch.
REQ-015 The block SHALL have port frm_cnt, output, 16 bits: the count of good frames delivered.

Function
REQ-016 Frame format SHALL be SYNC, LEN, LEN payload bytes, CHK, where (LEN + sum(payload) + CHK) mod 256 == 0.
REQ-017 The FSM SHALL have the states IDLE, LEN, DATA, CHK and OUT.
REQ-018 A byte SHALL be accepted only on a cycle where sti_tvalid and sti_tready are both 1.
REQ-019 sti_tready SHALL be 1 in IDLE, LEN, DATA and CHK, and 0 in OUT.
REQ-020 IDLE: an accepted byte equal to SYNC SHALL move the FSM to LEN; any other byte SHALL be discarded and the FSM SHALL stay in IDLE.
REQ-021 LEN: an accepted LEN of 0 or greater than MAXLEN SHALL pulse err_len for 1 cycle on the next clock and return the FSM to IDLE.
REQ-022 LEN: a legal LEN SHALL be stored, the write index and the 8-bit sum SHALL be set to 0 and LEN respectively, and the FSM SHALL go to DATA.
REQ-023 DATA: each accepted byte SHALL be written to buf[wr], wr SHALL increment, and sum SHALL add the byte mod 256.
REQ-024 DATA: after the LEN-th byte the FSM SHALL go to CHK.
REQ-025 CHK: an accepted byte with (sum + CHK) mod 256 == 0 SHALL move the FSM to OUT with rd = 0.
REQ-026 CHK: otherwise err_chk SHALL pulse for 1 cycle, the buffer SHALL be discarded, and the FSM SHALL return to IDLE.
REQ-027 A SYNC value received inside LEN, DATA or CHK SHALL be treated as ordinary data; there is no resynchronisation mid-frame.
REQ-028 OUT: sto_tvalid SHALL be 1 and sto_tdata SHALL equal buf[rd].
REQ-029 OUT: sto_tlast SHALL be 1 when rd == LEN-1.
REQ-030 OUT: rd SHALL advance only on sto_tvalid && sto_tready.
REQ-031 OUT: sto_tdata and sto_tlast SHALL be held stable while sto_tready is 0.
REQ-032 Latency: sto_tvalid SHALL rise on the clock edge after the good CHK byte is accepted.
REQ-033 The handshake of the tlast byte SHALL increment frm_cnt (wrapping 0xFFFF -> 0x0000) and return the FSM to IDLE.
REQ-034 Once a byte is accepted, sto_tvalid SHALL NOT deassert until that handshake occurs.
REQ-035 err_len and err_chk SHALL be registered and never both 1 in the same cycle.
REQ-036 sto_tvalid SHALL be 0 outside OUT.
REQ-037 Byte values in DATA SHALL be unrestricted (0x00..0xFF).

Reset
REQ-038 While rst is 1, the FSM SHALL be in IDLE.
REQ-039 While rst is 1, sto_tvalid, sto_tlast, err_len and err_chk SHALL be 0 and sto_tdata SHALL be 0.
REQ-040 While rst is 1, frm_cnt, sum, wr and rd SHALL be 0, and sti_tready SHALL be 0.
REQ-041 Reset asserted mid-frame, including during OUT, SHALL abort the frame immediately with no output handshake and no error pulse.
REQ-042 sti_tready SHALL be 1 from the first clock edge after rst deasserts.
REQ-043 Buffer contents need not be reset.

Verification
REQ-044 The bench SHALL drive A5 03 11 22 33 97 with sto_tready=1 -> require outputs 11, 22, 33(tlast), frm_cnt=1, and no error pulses.
REQ-045 The bench SHALL drive the same frame with CHK 98 -> require a single err_chk pulse, no sto_tvalid, and frm_cnt unchanged.
REQ-046 The bench SHALL drive 00 FF A5 00 and then A5 11 (MAXLEN=16) -> require leading garbage ignored and two err_len pulses, one each for LEN 00 and LEN 11, with no sto_tvalid.
REQ-047 The bench SHALL drive A5 01 A5 5A with sto_tready toggling 0/1 and random gaps on sti_tvalid -> require one output byte A5 with tlast, stable while stalled, and sti_tready=0 until the handshake.
REQ-048 The bench SHALL assert rst after the 2nd payload byte of A5 03 11 22 33 97, then send A5 02 01 02 FB -> require outputs 01, 02(tlast) and frm_cnt=1.
REQ-049 The bench SHALL preload frm_cnt to 0xFFFF via 65535 good 1-byte frames (or force), then send one good frame -> require frm_cnt=0x0000.

Source files
------------

// File: rtl/uart_frame_parser.sv
// Frame parser for a UART byte stream: SYNC, LEN, LEN payload bytes, CHK.
// Payloads that pass the checksum are buffered and replayed on an AXI-Stream-style output.
module uart_frame_parser #(
  parameter int unsigned    DW     = 8,
  parameter logic [DW-1:0]  SYNC   = DW'(8'hA5),
  parameter int unsigned    MAXLEN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sti_tvalid,
  input  logic [DW-1:0] sti_tdata,
  output logic          sti_tready,
  output logic          sto_tvalid,
  output logic [DW-1:0] sto_tdata,
  output logic          sto_tlast,
  input  logic          sto_tready,
  output logic          err_len,
  output logic          err_chk,
  output logic [15:0]   frm_cnt
);

  localparam int unsigned LW = 8;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] wr_q, wr_d;
  logic [LW-1:0] rd_q, rd_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic          tvalid_q, tvalid_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic          tlast_q, tlast_d;
  logic          err_len_q, err_len_d;
  logic          err_chk_q, err_chk_d;
  logic          buf_we;

  logic [DW-1:0] buf_mem [MAXLEN];

  logic          accept;
  logic          handshake;
  logic          len_ok;
  logic          chk_ok;
  logic          last_wr;
  logic          last_rd;
  logic [SW-1:0] sum_add;
  logic [LW-1:0] len_m1;
  logic [LW-1:0] rd_inc;

  assign accept    = sti_tvalid && rdy_q;
  assign handshake = tvalid_q && sto_tready;
  assign sum_add   = sum_q + SW'(sti_tdata);
  assign len_ok    = (sti_tdata != '0) && (sti_tdata <= DW'(MAXLEN));
  assign chk_ok    = (sum_add == '0);
  assign len_m1    = len_q - LW'(1);
  assign rd_inc    = rd_q + LW'(1);
  assign last_wr   = (wr_q == len_m1);
  assign last_rd   = (rd_q == len_m1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; SYNC bytes inside a frame are ordinary data
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && (sti_tdata == SYNC)) state_d = S_LEN;
      S_LEN:  if (accept) state_d = len_ok ? S_DATA : S_IDLE;
      S_DATA: if (accept && last_wr) state_d = S_CHK;
      S_CHK:  if (accept) state_d = chk_ok ? S_OUT : S_IDLE;
      S_OUT:  if (handshake && last_rd) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; every output leaves through a flop
  always_comb begin
    len_d     = len_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    buf_we    = 1'b0;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    tdata_d   = '0;
    tlast_d   = 1'b0;
    tvalid_d  = (state_d == S_OUT);
    rdy_d     = (state_d != S_OUT);
    unique case (state_q)
      S_LEN: begin
        if (accept) begin
          if (len_ok) begin
            len_d = LW'(sti_tdata);
            wr_d  = '0;
            sum_d = SW'(sti_tdata);
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          buf_we = 1'b1;
          wr_d   = wr_q + LW'(1);
          sum_d  = sum_add;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (chk_ok) begin
            rd_d    = '0;
            tdata_d = buf_mem[0];
            tlast_d = (len_q == LW'(1));
          end else begin
            err_chk_d = 1'b1;
          end
        end
      end
      S_OUT: begin
        tdata_d = tdata_q;
        tlast_d = tlast_q;
        if (handshake) begin
          if (last_rd) begin
            cnt_d   = cnt_q + CW'(1);
            tdata_d = '0;
            tlast_d = 1'b0;
          end else begin
            rd_d    = rd_inc;
            tdata_d = buf_mem[IW'(rd_inc)];
            tlast_d = (rd_inc == len_m1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
    end else begin
      len_q     <= len_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
    end
  end

  // Payload buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[IW'(wr_q)] <= sti_tdata;
  end

  assign sti_tready = rdy_q;
  assign sto_tvalid = tvalid_q;
  assign sto_tdata  = tdata_q;
  assign sto_tlast  = tlast_q;
  assign err_len    = err_len_q;
  assign err_chk    = err_chk_q;
  assign frm_cnt    = cnt_q;

endmodule
